// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-port word RAM,
// with load/store formatting, fault detection and one memory-mapped LED register.
module mem_arbiter #(
    parameter int              XLEN            = 32,
    parameter int              ALEN            = 32,
    parameter int              LED_WIDTH       = 4,
    parameter int              RAM_MEMORY_SIZE = 1024,
    parameter logic [ALEN-1:0] MMIO_LED_ADDR   = ALEN'(32'hFFFF_FFF0),
    parameter int              RAM_WORDS       = RAM_MEMORY_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         if_req_valid,
    output logic                         if_req_ready,
    input  logic [ALEN-1:0]              if_addr,
    output logic                         if_rsp_valid,
    output logic [XLEN-1:0]              if_rdata,
    input  logic                         ls_req_valid,
    output logic                         ls_req_ready,
    input  logic [ALEN-1:0]              ls_addr,
    input  logic                         ls_we,
    input  logic [2:0]                   ls_funct3,
    input  logic [XLEN-1:0]              ls_wdata,
    output logic                         ls_rsp_valid,
    output logic [XLEN-1:0]              ls_rdata,
    output logic                         ls_fault,
    output logic                         ram_en,
    output logic [3:0]                   ram_we,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic [XLEN-1:0]              ram_wdata,
    input  logic [XLEN-1:0]              ram_rdata,
    output logic [LED_WIDTH-1:0]         led_out
);

    localparam int AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Handshake: a request transfers on a rising edge where valid && ready.
    // Ready is only ever raised in IDLE, for at most one requester; after the
    // transfer the requester inputs are ignored until the response pulse.
    logic grant_if, grant_ls;
    logic acc_if, acc_ls;
    logic rr_ls;  // 1 = load/store wins the next tie

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        case (state)
            S_IDLE: begin
                grant_if = if_req_valid ? (!ls_req_valid || !rr_ls) : !ls_req_valid;
                grant_ls = ls_req_valid && !grant_if;
                if ((if_req_valid && grant_if) || (ls_req_valid && grant_ls))
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;
    assign acc_if       = if_req_valid && grant_if;
    assign acc_ls       = ls_req_valid && grant_ls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Request decode, evaluated on the raw inputs at the acceptance edge.
    logic            if_mmio, ls_mmio, ls_bad;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data;

    assign if_mmio = (if_addr == MMIO_LED_ADDR);
    assign ls_mmio = (ls_addr == MMIO_LED_ADDR);

    always_comb begin
        ls_bad  = 1'b0;
        st_mask = 4'b1111;
        st_data = ls_wdata;
        case (ls_funct3)
            3'b000:  ls_bad = 1'b0;
            3'b001:  ls_bad = ls_addr[0];
            3'b010:  ls_bad = |ls_addr[1:0];
            3'b100:  ls_bad = ls_we;
            3'b101:  ls_bad = ls_we || ls_addr[0];
            default: ls_bad = 1'b1;
        endcase
        case (ls_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << ls_addr[1:0];
                st_data = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = ls_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{ls_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = ls_wdata;
            end
        endcase
    end

    // Captured transaction context
    logic                 r_is_ls, r_we, r_fault, r_mmio;
    logic [2:0]           r_funct3;
    logic [1:0]           r_off;
    logic [LED_WIDTH-1:0] r_led_wdata;

    // Load formatting from the word the RAM returns during WAIT.
    logic [XLEN-1:0] shifted, load_data;

    always_comb begin
        shifted   = ram_rdata >> {r_off, 3'b000};
        load_data = ram_rdata;
        case (r_funct3)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ls        <= 1'b0;
            r_is_ls      <= 1'b0;
            r_we         <= 1'b0;
            r_fault      <= 1'b0;
            r_mmio       <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_led_wdata  <= '0;
            ram_en       <= 1'b0;
            ram_we       <= 4'b0000;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            led_out      <= '0;
            if_rsp_valid <= 1'b0;
            if_rdata     <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rdata     <= '0;
            ls_fault     <= 1'b0;
        end else begin
            ram_en       <= 1'b0;
            ram_we       <= 4'b0000;
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_fault     <= 1'b0;

            if (acc_if) begin
                r_is_ls  <= 1'b0;
                r_we     <= 1'b0;
                r_fault  <= 1'b0;
                r_mmio   <= if_mmio;
                ram_en   <= !if_mmio;
                ram_addr <= if_addr[AW+1:2];
                rr_ls    <= 1'b1;
            end else if (acc_ls) begin
                r_is_ls     <= 1'b1;
                r_we        <= ls_we;
                r_fault     <= ls_bad;
                r_mmio      <= ls_mmio;
                r_funct3    <= ls_funct3;
                r_off       <= ls_addr[1:0];
                r_led_wdata <= ls_wdata[LED_WIDTH-1:0];
                ram_en      <= !ls_bad && !ls_mmio;
                ram_addr    <= ls_addr[AW+1:2];
                if (ls_we && !ls_bad && !ls_mmio) begin
                    ram_we    <= st_mask;
                    ram_wdata <= st_data;
                end
                rr_ls       <= 1'b0;
            end

            if (state == S_ISSUE && r_is_ls && r_mmio && r_we && !r_fault)
                led_out <= r_led_wdata;

            if (state == S_WAIT) begin
                if (!r_is_ls) begin
                    if_rsp_valid <= 1'b1;
                    if_rdata     <= r_mmio ? '0 : ram_rdata;
                end else begin
                    ls_rsp_valid <= 1'b1;
                    ls_fault     <= r_fault;
                    if (r_fault || r_we)
                        ls_rdata <= '0;
                    else if (r_mmio)
                        ls_rdata <= {{(XLEN-LED_WIDTH){1'b0}}, led_out};
                    else
                        ls_rdata <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural word RAM answers ram_* and every
// scenario task checks the arbiter's outputs against hand-computed values.
module tb_mem_arbiter;

  localparam logic [31:0] LED_ADDR = 32'hFFFF_FFF0;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        ls_req_valid, ls_req_ready;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rdata;
  logic        ls_fault;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [3:0]  led_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] ram_w;
  logic        ram_en_seen;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .led_out(led_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural synchronous RAM: read data one cycle after ram_en
  always @(posedge clk) begin
    if (ram_en) begin
      ram_w = mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram_w[8*i +: 8] = ram_wdata[8*i +: 8];
      mem[ram_addr] <= ram_w;
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) if (ram_en) ram_en_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_cycle();
    @(posedge clk); #1;
  endtask

  task automatic accept_ls(input logic [31:0] a, input logic we, input logic [2:0] f3,
                           input logic [31:0] wd);
    bit ok = 1'b0;
    ls_addr = a; ls_we = we; ls_funct3 = f3; ls_wdata = wd; ls_req_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (ls_req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ls_accept: ls_req_ready got 0 exp 1"); end
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    ls_addr = $urandom; ls_we = 1'($urandom_range(0, 1));
    ls_funct3 = 3'($urandom_range(0, 7)); ls_wdata = $urandom;
    #1;
  endtask

  task automatic accept_if(input logic [31:0] a);
    bit ok = 1'b0;
    if_addr = a; if_req_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (if_req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL if_accept: if_req_ready got 0 exp 1"); end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    if_addr = $urandom;
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_funct3 = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b exp 1", if_req_ready); end
    checks++; if (ls_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ls_ready: got %b exp 0", ls_req_ready); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b exp 0", ram_en); end
    checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL reset_ram_we: got %b exp 0000", ram_we); end
    checks++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL reset_ram_addr: got %h exp 0", ram_addr); end
    checks++; if (ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_ram_wdata: got %h exp 0", ram_wdata); end
    checks++; if (led_out !== 4'd0) begin errors++; $display("FAIL reset_led: got %h exp 0", led_out); end
    checks++; if ({if_rsp_valid, ls_rsp_valid, ls_fault} !== 3'b000) begin errors++; $display("FAIL reset_rsp: got %b exp 000", {if_rsp_valid, ls_rsp_valid, ls_fault}); end
    checks++; if (if_rdata !== 32'd0) begin errors++; $display("FAIL reset_if_rdata: got %h exp 0", if_rdata); end
    checks++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL reset_ls_rdata: got %h exp 0", ls_rdata); end
    @(negedge clk) rst_n = 1'b1;
    wait_cycle();
  endtask

  task automatic test_round_robin();
    if_addr = 32'h10; if_req_valid = 1'b1;
    ls_addr = 32'h20; ls_we = 1'b0; ls_funct3 = 3'b010; ls_req_valid = 1'b1;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL rr_first_if_ready: got %b exp 1", if_req_ready); end
    checks++; if (ls_req_ready !== 1'b0) begin errors++; $display("FAIL rr_first_ls_ready: got %b exp 0", ls_req_ready); end
    @(posedge clk); #1;
    if_req_valid = 1'b0; if_addr = $urandom;
    #1;
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL rr_if_ram_en: got %b exp 1", ram_en); end
    checks++; if (ram_addr !== 10'd4) begin errors++; $display("FAIL rr_if_ram_addr: got %0d exp 4", ram_addr); end
    checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL rr_if_ram_we: got %b exp 0000", ram_we); end
    checks++; if (ls_req_ready !== 1'b0) begin errors++; $display("FAIL rr_busy_ls_ready: got %b exp 0", ls_req_ready); end
    wait_cycle();
    checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_if_rsp_early: got %b exp 0", if_rsp_valid); end
    wait_cycle();
    checks++; if (if_rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_if_rsp: got %b exp 1", if_rsp_valid); end
    checks++; if (if_rdata !== 32'hCAFE0004) begin errors++; $display("FAIL rr_if_rdata: got %h exp cafe0004", if_rdata); end
    checks++; if (ls_req_ready !== 1'b1) begin errors++; $display("FAIL rr_second_ls_ready: got %b exp 1", ls_req_ready); end
    @(posedge clk); #1;
    ls_req_valid = 1'b0; ls_addr = $urandom;
    #1;
    checks++; if (ram_addr !== 10'd8) begin errors++; $display("FAIL rr_ls_ram_addr: got %0d exp 8", ram_addr); end
    checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_if_rsp_pulse: got %b exp 0", if_rsp_valid); end
    wait_cycle(); wait_cycle();
    checks++; if (ls_rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_ls_rsp: got %b exp 1", ls_rsp_valid); end
    checks++; if (ls_rdata !== 32'hBEEF0008) begin errors++; $display("FAIL rr_ls_rdata: got %h exp beef0008", ls_rdata); end
  endtask

  task automatic test_pointer();
    // a lone fetch hands the next tie to load/store
    accept_if(32'h14);
    wait_cycle(); wait_cycle();
    checks++; if (if_rdata !== 32'h5555AAAA) begin errors++; $display("FAIL ptr_if_rdata: got %h exp 5555aaaa", if_rdata); end
    if_addr = 32'h10; if_req_valid = 1'b1;
    ls_addr = 32'h20; ls_we = 1'b0; ls_funct3 = 3'b010; ls_req_valid = 1'b1;
    #1;
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b01) begin errors++; $display("FAIL ptr_tie_ls: got %b exp 01", {if_req_ready, ls_req_ready}); end
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    wait_cycle(); wait_cycle();
    #1;
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b10) begin errors++; $display("FAIL ptr_after_ls_if: got %b exp 10", {if_req_ready, ls_req_ready}); end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    wait_cycle(); wait_cycle();
  endtask

  task automatic test_store_byte();
    accept_ls(32'h103, 1'b1, 3'b000, 32'h000000A5);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL sb_ram_en: got %b exp 1", ram_en); end
    checks++; if (ram_we !== 4'b1000) begin errors++; $display("FAIL sb_ram_we: got %b exp 1000", ram_we); end
    checks++; if (ram_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_ram_wdata: got %h exp a5a5a5a5", ram_wdata); end
    checks++; if (ram_addr !== 10'h40) begin errors++; $display("FAIL sb_ram_addr: got %h exp 40", ram_addr); end
    wait_cycle(); wait_cycle();
    checks++; if (ls_rsp_valid !== 1'b1) begin errors++; $display("FAIL sb_rsp: got %b exp 1", ls_rsp_valid); end
    checks++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL sb_rdata: got %h exp 0", ls_rdata); end
    accept_ls(32'h103, 1'b0, 3'b000, 32'h0);
    checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL lb_ram_we: got %b exp 0000", ram_we); end
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_rdata: got %h exp ffffffa5", ls_rdata); end
    accept_ls(32'h103, 1'b0, 3'b100, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'h000000A5) begin errors++; $display("FAIL lbu_rdata: got %h exp 000000a5", ls_rdata); end
  endtask

  task automatic test_store_half_and_faults();
    accept_ls(32'h42, 1'b1, 3'b001, 32'h00008001);
    checks++; if (ram_we !== 4'b1100) begin errors++; $display("FAIL sh_ram_we: got %b exp 1100", ram_we); end
    checks++; if (ram_wdata !== 32'h80018001) begin errors++; $display("FAIL sh_ram_wdata: got %h exp 80018001", ram_wdata); end
    wait_cycle(); wait_cycle();
    accept_ls(32'h42, 1'b0, 3'b001, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata: got %h exp ffff8001", ls_rdata); end
    accept_ls(32'h42, 1'b0, 3'b101, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata: got %h exp 00008001", ls_rdata); end
    accept_ls(32'h40, 1'b0, 3'b010, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'h80010000) begin errors++; $display("FAIL lw_rdata: got %h exp 80010000", ls_rdata); end

    ram_en_seen = 1'b0;
    accept_ls(32'h41, 1'b0, 3'b010, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if ({ls_rsp_valid, ls_fault} !== 2'b11) begin errors++; $display("FAIL lw_mis_fault: got %b exp 11", {ls_rsp_valid, ls_fault}); end
    checks++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL lw_mis_rdata: got %h exp 0", ls_rdata); end
    checks++; if (ram_en_seen !== 1'b0) begin errors++; $display("FAIL lw_mis_ram_en: got %b exp 0", ram_en_seen); end
    wait_cycle();
    checks++; if (ls_fault !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b exp 0", ls_fault); end

    ram_en_seen = 1'b0;
    accept_ls(32'h43, 1'b1, 3'b001, 32'hFFFF);
    wait_cycle(); wait_cycle();
    checks++; if ({ls_fault, ram_en_seen} !== 2'b10) begin errors++; $display("FAIL sh_mis: got %b exp 10", {ls_fault, ram_en_seen}); end
    ram_en_seen = 1'b0;
    accept_ls(32'h40, 1'b1, 3'b100, 32'hFF);
    wait_cycle(); wait_cycle();
    checks++; if ({ls_fault, ram_en_seen} !== 2'b10) begin errors++; $display("FAIL store_f3_100: got %b exp 10", {ls_fault, ram_en_seen}); end
    accept_ls(32'h40, 1'b0, 3'b011, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_fault !== 1'b1) begin errors++; $display("FAIL load_f3_011: got %b exp 1", ls_fault); end
    accept_ls(32'h40, 1'b0, 3'b010, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'h80010000) begin errors++; $display("FAIL mem_intact: got %h exp 80010000", ls_rdata); end
  endtask

  task automatic test_mmio();
    ram_en_seen = 1'b0;
    accept_ls(LED_ADDR, 1'b1, 3'b010, 32'h000000F5);
    checks++; if ({ram_en, ram_we} !== 5'b0) begin errors++; $display("FAIL led_sw_ram: got %b exp 00000", {ram_en, ram_we}); end
    wait_cycle(); wait_cycle();
    checks++; if (led_out !== 4'h5) begin errors++; $display("FAIL led_out: got %h exp 5", led_out); end
    checks++; if ({ls_rsp_valid, ls_fault} !== 2'b10) begin errors++; $display("FAIL led_sw_rsp: got %b exp 10", {ls_rsp_valid, ls_fault}); end
    checks++; if (ram_en_seen !== 1'b0) begin errors++; $display("FAIL led_sw_ram_seen: got %b exp 0", ram_en_seen); end
    accept_ls(32'h40, 1'b0, 3'b010, 32'h0);
    wait_cycle(); wait_cycle();
    accept_ls(LED_ADDR, 1'b0, 3'b010, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'h00000005) begin errors++; $display("FAIL led_lw: got %h exp 00000005", ls_rdata); end
    accept_ls(32'h40, 1'b0, 3'b010, 32'h0);
    wait_cycle(); wait_cycle();
    accept_ls(LED_ADDR, 1'b0, 3'b000, 32'h0);
    wait_cycle(); wait_cycle();
    checks++; if (ls_rdata !== 32'h00000005) begin errors++; $display("FAIL led_lb: got %h exp 00000005", ls_rdata); end
    accept_if(LED_ADDR);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL led_fetch_ram_en: got %b exp 0", ram_en); end
    wait_cycle(); wait_cycle();
    checks++; if ({if_rsp_valid, if_rdata} !== {1'b1, 32'd0}) begin errors++; $display("FAIL led_fetch: got %b/%h exp 1/0", if_rsp_valid, if_rdata); end
    checks++; if (ls_rdata !== 32'h00000005) begin errors++; $display("FAIL ls_rdata_hold: got %h exp 00000005", ls_rdata); end
  endtask

  task automatic test_reset_midflight();
    bit rsp_seen;
    accept_ls(LED_ADDR, 1'b1, 3'b010, 32'h0000000A);
    wait_cycle();
    checks++; if (led_out !== 4'hA) begin errors++; $display("FAIL mid_led_pre: got %h exp a", led_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led_out !== 4'h0) begin errors++; $display("FAIL mid_led_clear: got %h exp 0", led_out); end
    rsp_seen = 1'b0;
    repeat (2) begin wait_cycle(); rsp_seen |= ls_rsp_valid | if_rsp_valid; end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL mid_if_ready: got %b exp 1", if_req_ready); end
    repeat (4) begin wait_cycle(); rsp_seen |= ls_rsp_valid | if_rsp_valid; end
    checks++; if (rsp_seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b exp 0", rsp_seen); end

    // pointer left on load/store by a fetch grant must return to fetch-first
    accept_if(32'h10);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    wait_cycle();
    if_addr = 32'h10; if_req_valid = 1'b1;
    ls_addr = 32'h20; ls_we = 1'b0; ls_funct3 = 3'b010; ls_req_valid = 1'b1;
    #1;
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b10) begin errors++; $display("FAIL reset_ptr: got %b exp 10", {if_req_ready, ls_req_ready}); end
    checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_drop_fetch: got %b exp 0", if_rsp_valid); end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    wait_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[4] = 32'hCAFE0004;
    mem[5] = 32'h5555AAAA;
    mem[8] = 32'hBEEF0008;
    ram_rdata = 32'd0;
    ram_en_seen = 1'b0;
    test_reset();
    test_round_robin();
    test_pointer();
    test_store_byte();
    test_store_half_and_faults();
    test_mmio();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter ALEN, default 32, address width.
REQ-003 SHALL have parameter LED_WIDTH, default 4, LED register width.
REQ-004 SHALL have parameter RAM_WORDS, default RAM_MEMORY_SIZE, RAM depth in words; AW = $clog2(RAM_WORDS).
REQ-005 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ALEN  fetch byte address
- if_rsp_valid  out  1  fetch response pulse
- if_rdata  out  XLEN  fetched word
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_addr  in  ALEN  load/store byte address
- ls_we  in  1  1 = store, 0 = load
- ls_funct3  in  3  access size/sign (RV32I load/store funct3)
- ls_wdata  in  XLEN  store data, right-aligned
- ls_rsp_valid  out  1  load/store response pulse
- ls_rdata  out  XLEN  extended load data; 0 for stores and faults
- ls_fault  out  1  misaligned/illegal access, valid with ls_rsp_valid
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM byte-lane write enables
- ram_addr  out  AW  RAM word index
- ram_wdata  out  XLEN  lane-replicated store data
- ram_rdata  in  XLEN  RAM read data, valid the cycle after ram_en
- led_out  out  LED_WIDTH  MMIO LED register

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, one state per cycle; no other transitions.
REQ-007 SHALL assert if_req_ready/ls_req_ready only in IDLE, at most one per cycle; acceptance = valid && ready.
REQ-008 SHALL capture address, we, funct3, wdata and grant identity at acceptance; requester inputs are don't-care afterwards.
REQ-009 SHALL arbitrate round-robin when both valid in IDLE: pointer resets to fetch-first, flips to the other requester after each grant; a single valid requester is granted regardless of pointer.
REQ-010 SHALL, for a request accepted at edge ending cycle T, drive registered RAM outputs in T+1 (ISSUE), register ram_rdata in T+2 (WAIT), and assert the granted rsp_valid for exactly one cycle in T+3; IDLE in T+3 may accept a new request.
REQ-011 SHALL set ram_addr = addr[AW+1:2]; higher address bits ignored (wrap modulo RAM_WORDS).
REQ-012 SHALL treat fetch as word read; if_addr[1:0] ignored; ram_we = 0000.
REQ-013 SHALL drive stores: SB ram_we = 1<<addr[1:0], byte replicated x4; SH ram_we = 0011 (addr[1]=0) or 1100, halfword replicated x2; SW ram_we = 1111.
REQ-014 SHALL format loads from the registered word: LB/LBU byte at addr[1:0] sign/zero-extended; LH/LHU halfword at addr[1] sign/zero-extended; LW whole word.
REQ-015 SHALL flag fault (no RAM, no LED access, ls_rdata = 0, ls_fault = 1 in T+3) for: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 in {011,110,111}; stores with funct3 in {100,101}.
REQ-016 SHALL decode ls_addr == MMIO_LED_ADDR as MMIO: store writes led_out <= wdata[LED_WIDTH-1:0] in ISSUE, ram_en = 0; load returns zero-extended led_out regardless of size; latency per REQ-010.
REQ-017 SHALL return if_rdata = 0 for a fetch from MMIO_LED_ADDR, ram_en = 0.
REQ-018 SHALL hold ram_en, ram_we at 0 outside ISSUE; rsp_valid, ls_fault 0 outside response cycle; rdata holds last value.

Reset
REQ-019 SHALL, on rst_n low (asynchronous, any state), enter IDLE, drop any in-flight access without response, clear led_out, all ram_* outputs, rsp_valid, ls_fault, rdata to 0, and set pointer to fetch-first.
REQ-020 SHALL resume normal operation from the first rising clk edge after rst_n deasserts.

Verification
REQ-021 Both valid after reset, if_addr=0x10, ls load LW 0x20 -> fetch granted first (if_rsp_valid at T+3), load granted next IDLE cycle; ram_addr 4 then 8.
REQ-022 SB addr 0x103, wdata 0x000000A5 -> ram_we=1000, ram_wdata=0xA5A5A5A5; then LB 0x103 -> ls_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
REQ-023 SH addr 0x42 wdata 0x8001 -> ram_we=1100; LH 0x42 -> 0xFFFF8001; LW 0x41 -> ls_fault=1, ls_rdata=0, ram_en never asserted.
REQ-024 SW 0xFFFFFFF0 wdata 0xF5 -> led_out=0x5, ram_en=0; LW same address -> ls_rdata=0x00000005.
REQ-025 rst_n low during WAIT of a store to LED -> no rsp_valid, led_out=0, if_req_ready high first cycle after release.
